// File: rtl/led_pattern_driver.sv
// rtl/led_pattern_driver.sv - multi-channel LED pattern generator
// Shared prescaler/phase drive per-channel blink, heartbeat and activity-stretch modes.
module led_pattern_driver #(
  parameter int NUM_LEDS      = 4,
  parameter int PRESCALE_BITS = 20,
  parameter int STRETCH_TICKS = 8,
  parameter int ACTIVE_HIGH   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3*NUM_LEDS-1:0] mode,
  input  logic [NUM_LEDS-1:0]   activity,
  output logic [NUM_LEDS-1:0]   led,
  output logic                  tick
);

  localparam int CW = $clog2(STRETCH_TICKS + 1);
  localparam logic [NUM_LEDS-1:0]      INV       = (ACTIVE_HIGH == 0) ? '1 : '0;
  localparam logic [CW-1:0]            LOAD      = CW'(STRETCH_TICKS);
  localparam logic [CW-1:0]            CNT_ONE   = CW'(1);
  localparam logic [PRESCALE_BITS-1:0] PS_ONE    = PRESCALE_BITS'(1);

  logic [PRESCALE_BITS-1:0] prescaler;
  logic [4:0]               phase;
  logic [CW-1:0]            stretch [NUM_LEDS];
  logic [NUM_LEDS-1:0]      act;
  logic [NUM_LEDS-1:0]      lit;
  logic                     wrap;
  logic                     slow;
  logic                     fast;
  logic                     hb;

  assign wrap = &prescaler;
  assign slow = phase[4];
  assign fast = phase[2];
  assign hb   = (phase[4:3] == 2'b00) && !phase[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      phase     <= '0;
      tick      <= 1'b0;
      led       <= INV;
    end else begin
      prescaler <= prescaler + PS_ONE;
      tick      <= wrap;
      if (wrap) begin
        phase <= phase + 5'd1;
      end
      led <= lit ^ INV;
    end
  end

  // A fresh activity strobe reloads the counter even on a decrement cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (reset) begin
        stretch[i] <= '0;
      end else if (activity[i]) begin
        stretch[i] <= LOAD;
      end else if (wrap && (stretch[i] != '0)) begin
        stretch[i] <= stretch[i] - CNT_ONE;
      end
    end
  end

  always_comb begin
    act = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      act[i] = (stretch[i] != '0);
    end
  end

  always_comb begin
    lit = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (mode[3*i +: 3])
        3'd1:    lit[i] = 1'b1;
        3'd2:    lit[i] = slow;
        3'd3:    lit[i] = fast;
        3'd4:    lit[i] = act[i];
        3'd5:    lit[i] = act[i] ? fast : 1'b1;
        3'd6:    lit[i] = hb;
        default: lit[i] = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_driver.sv
// tb/tb_led_pattern_driver.sv - self-checking bench for led_pattern_driver
// Two instances (active-high and active-low pins) share stimulus and a cycle-count model.
module tb_led_pattern_driver;

  localparam int N  = 4;
  localparam int PB = 2;
  localparam int S  = 3;
  localparam int T  = 1 << PB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3*N-1:0] mode = '0;
  logic [N-1:0]  activity = '0;
  logic [N-1:0]  led, led_n;
  logic          tick, tick_n;

  always #5 clk = ~clk;

  led_pattern_driver #(.NUM_LEDS(N), .PRESCALE_BITS(PB), .STRETCH_TICKS(S), .ACTIVE_HIGH(1)) dut (
    .clk(clk), .reset(reset), .mode(mode), .activity(activity), .led(led), .tick(tick));

  led_pattern_driver #(.NUM_LEDS(N), .PRESCALE_BITS(PB), .STRETCH_TICKS(S), .ACTIVE_HIGH(0)) dut_n (
    .clk(clk), .reset(reset), .mode(mode), .activity(activity), .led(led_n), .tick(tick_n));

  int errors = 0;
  int checks = 0;
  int k = 0;
  int load_e [N];
  logic [N-1:0] exp_led = '0;
  logic exp_tick = 1'b0;

  // k = edges since the reset edge; load_e = edge at which a channel's stretch was last loaded.
  function automatic logic lit_fn(logic [2:0] md, int kk, int ch);
    int ph;
    logic a;
    logic f;
    ph = (kk / T) % 32;
    a  = (load_e[ch] >= 0) && ((kk / T - load_e[ch] / T) < S);
    f  = ((ph / 4) % 2) == 1;
    case (md)
      3'd1:    return 1'b1;
      3'd2:    return ph >= 16;
      3'd3:    return f;
      3'd4:    return a;
      3'd5:    return a ? f : 1'b1;
      3'd6:    return (ph < 8) && ((ph / 2) % 2 == 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    logic r;
    logic [3*N-1:0] m;
    logic [N-1:0] a;
    r = reset; m = mode; a = activity;
    @(posedge clk);
    #1;
    if (r) begin
      k = 0;
      for (int i = 0; i < N; i++) load_e[i] = -1;
      exp_led  = '0;
      exp_tick = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) exp_led[i] = lit_fn(m[3*i +: 3], k, i);
      k++;
      for (int i = 0; i < N; i++) if (a[i]) load_e[i] = k;
      exp_tick = (k % T) == 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    activity = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = '0; activity = '0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if ({led, led_n, tick, tick_n} !== {4'h0, 4'hf, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold c=%0d got led=%b led_n=%b tick=%b/%b exp 0000/1111/0/0", c, led, led_n, tick, tick_n);
      end
    end
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      checks++;
      if ({led, led_n, tick, tick_n} !== {exp_led, ~exp_led, exp_tick, exp_tick}) begin
        errors++;
        $display("FAIL reset_release k=%0d got %b %b %b %b exp %b %b %b", k, led, led_n, tick, tick_n, exp_led, ~exp_led, exp_tick);
      end
      checks++;
      if (tick !== ((k % 4) == 0)) begin
        errors++;
        $display("FAIL first_tick k=%0d got %b exp %b", k, tick, (k % 4) == 0);
      end
    end
  endtask

  task automatic test_blink();
    mode = {3'd0, 3'd0, 3'd3, 3'd2};
    do_reset();
    for (int c = 0; c < 260; c++) begin
      step();
      checks++;
      if ({led, led_n, tick, tick_n} !== {exp_led, ~exp_led, exp_tick, exp_tick}) begin
        errors++;
        $display("FAIL blink k=%0d got %b %b %b exp %b %b", k, led, led_n, tick, exp_led, exp_tick);
      end
      if (k == 64 || k == 65 || k == 128 || k == 129) begin
        checks++;
        if (led[0] !== (k == 65 || k == 128)) begin
          errors++;
          $display("FAIL slow_edge k=%0d got %b exp %b", k, led[0], (k == 65 || k == 128));
        end
      end
      if (k == 16 || k == 17) begin
        checks++;
        if (led[1] !== (k == 17)) begin
          errors++;
          $display("FAIL fast_edge k=%0d got %b exp %b", k, led[1], k == 17);
        end
      end
    end
  endtask

  task automatic test_stretch();
    mode = {3'd0, 3'd4, 3'd0, 3'd0};
    do_reset();
    while (k < 40) begin
      activity = (k == 10 || k == 17) ? 4'b0100 : 4'b0000;
      step();
      checks++;
      if ({led, led_n, tick, tick_n} !== {exp_led, ~exp_led, exp_tick, exp_tick}) begin
        errors++;
        $display("FAIL stretch k=%0d got %b %b %b exp %b %b", k, led, led_n, tick, exp_led, exp_tick);
      end
      checks++;
      if (led[2] !== (k >= 12 && k <= 28)) begin
        errors++;
        $display("FAIL stretch_window k=%0d got %b exp %b", k, led[2], (k >= 12 && k <= 28));
      end
    end
    activity = '0;
  endtask

  task automatic test_link();
    mode = {3'd5, 3'd0, 3'd0, 3'd0};
    do_reset();
    for (int c = 0; c < 120; c++) begin
      activity = (c >= 20 && c < 60) ? 4'b1000 : 4'b0000;
      step();
      checks++;
      if ({led, led_n, tick, tick_n} !== {exp_led, ~exp_led, exp_tick, exp_tick}) begin
        errors++;
        $display("FAIL link k=%0d got %b %b %b exp %b %b", k, led, led_n, tick, exp_led, exp_tick);
      end
      if (k <= 21 || k >= 73) begin
        checks++;
        if (led[3] !== 1'b1) begin
          errors++;
          $display("FAIL link_steady k=%0d got %b exp 1", k, led[3]);
        end
      end
    end
    activity = '0;
  endtask

  task automatic test_heartbeat();
    int ph;
    mode = {3'd0, 3'd0, 3'd0, 3'd6};
    do_reset();
    for (int c = 0; c < 140; c++) begin
      step();
      ph = ((k - 1) / T) % 32;
      checks++;
      if (led[0] !== (ph inside {0, 1, 4, 5})) begin
        errors++;
        $display("FAIL heartbeat k=%0d phase=%0d got %b exp %b", k, ph, led[0], (ph inside {0, 1, 4, 5}));
      end
    end
    mode[2:0] = 3'd1;
    step();
    checks++;
    if (led[0] !== 1'b1) begin
      errors++;
      $display("FAIL mode_switch_on got %b exp 1", led[0]);
    end
    mode[2:0] = 3'd0;
    step();
    checks++;
    if (led[0] !== 1'b0 || led_n[0] !== 1'b1) begin
      errors++;
      $display("FAIL mode_switch_off got %b/%b exp 0/1", led[0], led_n[0]);
    end
  endtask

  task automatic test_active_low_reset();
    mode = {3'd4, 3'd4, 3'd3, 3'd4};
    do_reset();
    activity = 4'b1011;
    step();
    activity = '0;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if ({led, led_n, tick, tick_n} !== {exp_led, ~exp_led, exp_tick, exp_tick}) begin
        errors++;
        $display("FAIL pre_reset k=%0d got %b %b %b exp %b %b", k, led, led_n, tick, exp_led, exp_tick);
      end
    end
    reset = 1'b1;
    step();
    checks++;
    if ({led_n, tick_n, led, tick} !== {4'hf, 1'b0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset got led_n=%b tick_n=%b led=%b tick=%b exp 1111 0 0000 0", led_n, tick_n, led, tick);
    end
    reset = 1'b0;
    mode = {4{3'd4}};
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if (led_n !== 4'hf || tick_n !== ((k % 4) == 0)) begin
        errors++;
        $display("FAIL post_reset k=%0d got led_n=%b tick_n=%b exp 1111 %b", k, led_n, tick_n, (k % 4) == 0);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(15) == 0) mode[3*$urandom_range(N-1) +: 3] = 3'($urandom_range(7));
      for (int i = 0; i < N; i++) activity[i] = ($urandom_range(7) == 0);
      reset = ($urandom_range(199) == 0);
      step();
      checks++;
      if ({led, led_n, tick, tick_n} !== {exp_led, ~exp_led, exp_tick, exp_tick}) begin
        errors++;
        $display("FAIL random k=%0d mode=%h got %b %b %b exp %b %b", k, mode, led, led_n, tick, exp_led, exp_tick);
      end
    end
    reset = 1'b0;
    activity = '0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) load_e[i] = -1;
    test_reset();
    test_blink();
    test_stretch();
    test_link();
    test_heartbeat();
    test_active_low_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
